// File: rtl/img_pkg.sv
// Shared image-pipeline constants: pixel/window widths, window tap indices and
// default frame geometry used by the window generator and the convolution blocks.
package img_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 9 * PIX_W;

    // Tap indices into the packed window, row-major, oldest row/column first.
    localparam int TL = 0;
    localparam int TC = 1;
    localparam int TR = 2;
    localparam int ML = 3;
    localparam int MC = 4;
    localparam int MR = 5;
    localparam int BL = 6;
    localparam int BC = 7;
    localparam int BR = 8;

    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;

endpackage

// File: rtl/line_delay.sv
// One-row pixel delay: circular RAM with combinational read and clocked write
// at a shared address, giving read-before-write behaviour at that address.
module line_delay #(
    parameter  int DEPTH = 512,
    parameter  int PIX_W = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    // Contents are never cleared; downstream row gating hides stale data.
    logic [PIX_W-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Builds a sliding 3x3 neighbourhood from a raster pixel stream using two
// full-row line delays; emits one window per interior pixel, 1-cycle latency.
module window_3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = img_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pixel_in,
    input  logic               pixel_in_valid,
    input  logic               sof,
    output logic [9*PIX_W-1:0] pixel_data,
    output logic               pixel_data_valid,
    output logic               frame_done
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [CW-1:0]    ptr;
    logic [CW-1:0]    pos_col;
    logic [RW-1:0]    pos_row;
    logic             at_last_col;
    logic             at_last_row;
    logic             win_ok;
    logic             accept;
    logic [PIX_W-1:0] l1_out;
    logic [PIX_W-1:0] l2_out;
    logic [PIX_W-1:0] w [3][3];

    // sof overrides the counters so the pixel is taken as (0,0).
    always_comb begin
        pos_col     = sof ? '0 : col;
        pos_row     = sof ? '0 : row;
        at_last_col = (pos_col == COL_LAST);
        at_last_row = (pos_row == ROW_LAST);
        win_ok      = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
        accept      = pixel_in_valid && !rst;
    end

    line_delay #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_l1 (
        .clk  (clk),
        .we   (accept),
        .addr (ptr),
        .din  (pixel_in),
        .dout (l1_out)
    );

    line_delay #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_l2 (
        .clk  (clk),
        .we   (accept),
        .addr (ptr),
        .din  (l1_out),
        .dout (l2_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col              <= '0;
            row              <= '0;
            ptr              <= '0;
            pixel_data_valid <= 1'b0;
            frame_done       <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w[r][c] <= '0;
                end
            end
        end else begin
            pixel_data_valid <= pixel_in_valid && win_ok;
            frame_done       <= pixel_in_valid && at_last_col && at_last_row;
            if (pixel_in_valid) begin
                // Pointer is deliberately not realigned on sof: a full-row
                // delay does not depend on its phase.
                ptr <= (ptr == COL_LAST) ? '0 : ptr + 1'b1;
                if (at_last_col) begin
                    col <= '0;
                    row <= at_last_row ? '0 : pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
                for (int r = 0; r < 3; r++) begin
                    w[r][0] <= w[r][1];
                    w[r][1] <= w[r][2];
                end
                w[0][2] <= l2_out;
                w[1][2] <= l1_out;
                w[2][2] <= pixel_in;
            end
        end
    end

    // The window registers are the output register; packing is wiring only.
    always_comb begin
        pixel_data = '0;
        for (int i = TL; i <= BR; i++) begin
            pixel_data[i*PIX_W +: PIX_W] = w[i/3][i%3];
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomised bench for window_3x3_gen on a 5x4 frame; windows are predicted
// from the accepted pixel stream and frame position held in the bench.
module tb_window_3x3_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic        sof;
    logic [71:0] pixel_data;
    logic        pixel_data_valid;
    logic        frame_done;

    window_3x3_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIX_W      (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pixel_in         (pixel_in),
        .pixel_in_valid   (pixel_in_valid),
        .sof              (sof),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference state: accepted stream since reset and raster position
    logic [7:0]  hist [$];
    int          mrow;
    int          mcol;
    logic [71:0] exp_data;
    logic        exp_known;
    logic        exp_v;
    logic        exp_fd;

    // per-frame statistics observed on the DUT outputs
    int          dut_wins;
    int          dut_fds;
    int          fd_with_v;
    logic [71:0] first_win;
    logic [71:0] last_win;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Window as a function of the stream: row r taps are delayed by (2-r) rows,
    // column c is the (2-c)-th most recent shift. Taps before any shift since
    // reset are 0; taps reading RAM not yet written since reset are unknown.
    task automatic model_window();
        int n;
        int j;
        int d;
        n         = hist.size();
        exp_known = 1'b1;
        exp_data  = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                d = (2 - r) * W;
                j = n - 3 + c;
                if (j >= 0) begin
                    if (j - d < 0) exp_known = 1'b0;
                    else exp_data[(3*r+c)*8 +: 8] = hist[j-d];
                end
            end
        end
    endtask

    task automatic clear_stats();
        dut_wins  = 0;
        dut_fds   = 0;
        fd_with_v = 0;
        first_win = '0;
        last_win  = '0;
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] p, input logic r);
        int pr;
        int pc;
        rst            = r;
        pixel_in_valid = v;
        sof            = s;
        pixel_in       = p;
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            mrow      = 0;
            mcol      = 0;
            exp_v     = 1'b0;
            exp_fd    = 1'b0;
            exp_data  = '0;
            exp_known = 1'b1;
        end else if (v) begin
            pr     = s ? 0 : mrow;
            pc     = s ? 0 : mcol;
            exp_v  = (pr >= 2) && (pc >= 2);
            exp_fd = (pr == H - 1) && (pc == W - 1);
            if (pc == W - 1) begin
                mcol = 0;
                mrow = (pr == H - 1) ? 0 : pr + 1;
            end else begin
                mcol = pc + 1;
                mrow = pr;
            end
            hist.push_back(p);
            model_window();
        end else begin
            exp_v  = 1'b0;
            exp_fd = 1'b0;
        end
        check("valid", 72'(pixel_data_valid), 72'(exp_v));
        check("frame_done", 72'(frame_done), 72'(exp_fd));
        if (exp_known) check("pixel_data", pixel_data, exp_data);
        if (pixel_data_valid) begin
            if (dut_wins == 0) first_win = pixel_data;
            last_win = pixel_data;
            dut_wins++;
        end
        if (frame_done) dut_fds++;
        if (frame_done && pixel_data_valid) fd_with_v++;
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic send_pixels(input int base, input int count, input logic with_sof,
                               input int max_gap, input logic rnd);
        logic [7:0] p;
        for (int i = 0; i < count; i++) begin
            for (int g = 0; g < int'($urandom_range(0, max_gap)); g++) idle();
            p = rnd ? 8'($urandom) : 8'(base + 16 * (i / W) + (i % W));
            step(1'b1, with_sof && (i == 0), p, 1'b0);
        end
    endtask

    localparam logic [71:0] F1_FIRST = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] F1_LAST  = 72'h34_33_32_24_23_22_14_13_12;
    localparam logic [71:0] F2_FIRST = 72'hA2_A1_A0_92_91_90_82_81_80;
    localparam logic [71:0] F5_FIRST = 72'hE2_E1_E0_D2_D1_D0_C2_C1_C0;

    initial begin
        rst = 1'b1; pixel_in = '0; pixel_in_valid = 1'b0; sof = 1'b0;
        mrow = 0; mcol = 0; exp_data = '0; exp_known = 1'b0; exp_v = 1'b0; exp_fd = 1'b0;
        clear_stats();
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h55, 1'b1);
        check("reset_data", pixel_data, 72'h0);

        // 1: continuous frame
        clear_stats();
        send_pixels(0, W * H, 1'b1, 0, 1'b0);
        idle();
        check("t1_windows", 72'(dut_wins), 72'd6);
        check("t1_first", first_win, F1_FIRST);
        check("t1_last", last_win, F1_LAST);
        check("t1_fd_count", 72'(dut_fds), 72'd1);
        check("t1_fd_with_valid", 72'(fd_with_v), 72'd1);

        // 2: same frame with random gaps
        clear_stats();
        send_pixels(0, W * H, 1'b1, 3, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        check("t2_windows", 72'(dut_wins), 72'd6);
        check("t2_first", first_win, F1_FIRST);
        check("t2_last", last_win, F1_LAST);

        // 3: back-to-back frames
        clear_stats();
        send_pixels(0, W * H, 1'b1, 0, 1'b0);
        check("t3_windows_f1", 72'(dut_wins), 72'd6);
        clear_stats();
        send_pixels(8'h80, W * H, 1'b1, 0, 1'b0);
        idle();
        check("t3_windows_f2", 72'(dut_wins), 72'd6);
        check("t3_first_f2", first_win, F2_FIRST);

        // 4: reset concurrent with pixel (2,4), restart without sof
        clear_stats();
        send_pixels(0, 14, 1'b1, 0, 1'b0);
        step(1'b1, 1'b0, 8'h24, 1'b1);
        check("t4_reset_data", pixel_data, 72'h0);
        check("t4_reset_valid", 72'(pixel_data_valid), 72'd0);
        clear_stats();
        send_pixels(0, W * H, 1'b0, 1, 1'b0);
        idle();
        check("t4_windows", 72'(dut_wins), 72'd6);
        check("t4_first", first_win, F1_FIRST);

        // 5: sof mid-frame at a random position
        clear_stats();
        send_pixels(8'h40, int'($urandom_range(3, W * H - 2)), 1'b1, 1, 1'b0);
        clear_stats();
        send_pixels(8'hC0, W * H, 1'b1, 2, 1'b0);
        idle();
        check("t5_windows", 72'(dut_wins), 72'd6);
        check("t5_first", first_win, F5_FIRST);
        check("t5_fd_count", 72'(dut_fds), 72'd1);

        // random pixel values, several frames
        clear_stats();
        for (int f = 0; f < 3; f++) send_pixels(0, W * H, 1'b1, 2, 1'b1);
        idle();
        check("rnd_windows", 72'(dut_wins), 72'd18);
        check("rnd_fd_count", 72'(dut_fds), 72'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
